serdes_deserializer_db: RTL and testbench
=========================================

SERDES_DESERIALIZER_DB -- requirements
Module: serdes_deserializer_db

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 8: maximum words per frame; legal range 2..64.
REQ-002 SHALL have parameter BIT_WIDTH, default 32: bits per word.
REQ-003 SHALL have parameter REVERSE, default 0: 0 stores the first word in slot 0; 1 stores it in slot frame_len-1.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- recv_val  in  1  input word valid.
- recv_rdy  out  1  block accepts an input word.
- recv_msg  in  BIT_WIDTH  input word.
- cfg_len  in  LW  requested frame length, with LW = $clog2(N_SAMPLES+1).
- send_val  out  1  output frame valid.
- send_rdy  in  1  consumer accepts the frame.
- send_msg  out  BIT_WIDTH x N_SAMPLES, unpacked array [N_SAMPLES-1:0]  frame words.
- send_len  out  LW  number of meaningful slots in send_msg.

Function
REQ-005 SHALL hold two register banks: an assembly bank, filled word by word, and an output bank, presented on send_msg.
REQ-006 SHALL treat a transfer as occurring on any cycle where val and rdy are both high on the same interface.
REQ-007 SHALL sample cfg_len on the first accepted word of each frame, into frame_len; later cfg_len changes SHALL NOT affect the frame in progress.
REQ-008 SHALL clamp the effective length: cfg_len of 0 or greater than N_SAMPLES SHALL be treated as N_SAMPLES.
REQ-009 SHALL write accepted word k (k = 0..frame_len-1) to slot k when REVERSE=0, and to slot frame_len-1-k when REVERSE=1.
REQ-010 SHALL keep a fill counter, count, of width $clog2(N_SAMPLES); it increments on each accepted word.
REQ-011 SHALL, on acceptance of word frame_len-1: set asm_full, return count to 0 and wrap with no overflow.
REQ-012 SHALL perform a bank move on any cycle where asm_full and (!send_val or send_rdy):
- output bank <= assembly bank, with slots at index >= frame_len forced to 0;
- send_len <= frame_len;
- send_val <= 1;
- asm_full <= 0.
REQ-013 SHALL drive recv_rdy = !asm_full | !send_val | send_rdy, combinationally; this is the only combinational path from send_rdy.
REQ-014 SHALL, when a bank move and a recv transfer coincide, write the accepted word as word 0 of the new frame; there is no bubble.
REQ-015 SHALL clear send_val after a send transfer when no bank move occurs in the same cycle.
REQ-016 SHALL hold send_msg and send_len stable while send_val=1 and send_rdy=0.
REQ-017 SHALL have a latency of 2 cycles from the cycle the last word is accepted to send_val=1.
REQ-018 SHALL sustain a throughput of 1 word/cycle when send_rdy is held at 1.
REQ-019 SHALL accept at most one extra complete frame while the output is stalled; recv_rdy falls once both banks are full.
REQ-020 SHALL work when frame_len=1: every accepted word forms a complete frame.

Reset
REQ-021 SHALL, while reset is high, clear:
- count, asm_full and frame_len;
- send_val = 0 and send_len = 0;
- send_msg: all slots 0.
REQ-022 SHALL discard any partial frame on reset asserted mid-frame; the first word accepted after reset is word 0.
REQ-023 SHALL drive recv_rdy = 1 in the first cycle after reset deasserts.

Structure
REQ-024 SHALL place the length-clamp function and LW width helper in the shared package serdes_pkg.
REQ-025 SHALL implement the counter, asm_full and bank-move handshake in sub-module serdes_deser_db_ctrl; the top level holds only the banks and slot-enable decode.
REQ-026 SHALL use the existing cmn_EnResetReg for every bank register.

Verification
REQ-027 SHALL cover a basic frame: N=8, cfg_len=8, words 1..8 back-to-back, send_rdy=1 -> send_val at cycle 10 with send_msg[0..7]=1..8 and send_len=8.
REQ-028 SHALL cover a short frame with REVERSE=1: cfg_len=3, words A,B,C -> send_msg[2]=A, [1]=B, [0]=C, slots 3..7=0, send_len=3.
REQ-029 SHALL cover backpressure: send_rdy=0, 16 words at cfg_len=8 -> recv_rdy=0 after the 16th accept; frame 1 held stable; raise send_rdy -> frame 1 then frame 2 appear in order.
REQ-030 SHALL cover a length change mid-frame: cfg_len=4 at word 0, changed to 2 at word 1 -> frame closes after 4 words; the next frame closes after 2.
REQ-031 SHALL cover clamping: cfg_len=0 and cfg_len=15 with N=8 -> both give 8-word frames with send_len=8.
REQ-032 SHALL cover reset mid-frame: reset after 5 of 8 words -> send_val stays 0; the next 8 words form a clean frame starting at slot 0.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared helpers for the SERDES blocks.
//   len_width : width of a length field able to hold 0..n_samples
//   clamp_len : maps a requested frame length onto 1..n_samples
//               (0 or anything above n_samples means "full frame")
package serdes_pkg;

  function automatic int unsigned len_width(input int unsigned n_samples);
    return $clog2(n_samples + 1);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned req,
                                            input int unsigned n_samples);
    return (req == 0 || req > n_samples) ? n_samples : req;
  endfunction

endpackage

// File: rtl/cmn_EnResetReg.sv
// Common enable register with synchronous active-high reset.
//   clk   : clock
//   reset : synchronous reset, loads p_reset_value
//   en    : load enable
//   d     : next value
//   q     : registered value
module cmn_EnResetReg #(
  parameter int unsigned          p_nbits       = 1,
  parameter logic [p_nbits-1:0]   p_reset_value = '0
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [p_nbits-1:0] d,
  output logic [p_nbits-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= p_reset_value;
    else if (en) q <= d;
  end

endmodule

// File: rtl/serdes_deser_db_ctrl.sv
// Control path of the double-buffered deserializer: fill counter, frame
// length capture, assembly-full flag and the output-bank handshake.
//   clk, reset : clock, synchronous active-high reset
//   recv_val   : input word valid
//   recv_rdy   : block accepts an input word (combinational)
//   cfg_len    : requested frame length, sampled on word 0
//   send_val   : output frame valid
//   send_rdy   : consumer accepts the frame
//   send_len   : meaningful slots in the output bank
//   wr_en      : an input word is accepted this cycle
//   count      : index of the word being accepted
//   cur_len    : length of the frame the accepted word belongs to
//   frame_len  : registered length of the frame in the assembly bank
//   move       : assembly bank is copied to the output bank this cycle
module serdes_deser_db_ctrl
  import serdes_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned LW        = 4,
  parameter int unsigned CW        = 3
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          recv_val,
  output logic          recv_rdy,
  input  logic [LW-1:0] cfg_len,
  output logic          send_val,
  input  logic          send_rdy,
  output logic [LW-1:0] send_len,
  output logic          wr_en,
  output logic [CW-1:0] count,
  output logic [LW-1:0] cur_len,
  output logic [LW-1:0] frame_len,
  output logic          move
);

  logic asm_full;
  logic send_xfer;
  logic last_word;

  assign recv_rdy  = !asm_full || !send_val || send_rdy;
  assign wr_en     = recv_val && recv_rdy;
  assign send_xfer = send_val && send_rdy;
  assign move      = asm_full && (!send_val || send_rdy);

  // Word 0 has no captured length yet, so it uses the clamped request
  // directly; later words use the value captured with word 0.
  always_comb begin
    cur_len = frame_len;
    if (count == '0) cur_len = LW'(clamp_len(32'(cfg_len), N_SAMPLES));
  end

  assign last_word = wr_en && (LW'(count) == cur_len - LW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      asm_full  <= 1'b0;
      frame_len <= '0;
      send_val  <= 1'b0;
      send_len  <= '0;
    end else begin
      if (wr_en) begin
        if (count == '0) frame_len <= cur_len;
        if (last_word)   count     <= '0;
        else             count     <= count + CW'(1);
      end

      // A new frame completing in the same cycle as a move keeps the flag set.
      if (last_word) asm_full <= 1'b1;
      else if (move) asm_full <= 1'b0;

      if (move) begin
        send_val <= 1'b1;
        send_len <= frame_len;
      end else if (send_xfer) begin
        send_val <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serdes_deserializer_db.sv
// Double-buffered deserializer: collects up to N_SAMPLES words of BIT_WIDTH
// bits into an assembly bank, then moves the completed frame into an output
// bank presented on send_msg while the next frame is being assembled.
//   clk, reset : clock, synchronous active-high reset
//   recv_val/recv_rdy/recv_msg : word input handshake
//   cfg_len    : requested frame length (0 or > N_SAMPLES = N_SAMPLES)
//   send_val/send_rdy          : frame output handshake
//   send_msg   : frame words, slots >= send_len read as 0
//   send_len   : number of meaningful slots
module serdes_deserializer_db
  import serdes_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned REVERSE   = 0,
  localparam int unsigned LW       = len_width(N_SAMPLES)
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic [LW-1:0]        cfg_len,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0],
  output logic [LW-1:0]        send_len
);

  localparam int unsigned CW = $clog2(N_SAMPLES);

  logic                 wr_en;
  logic                 move;
  logic [CW-1:0]        count;
  logic [LW-1:0]        cur_len;
  logic [LW-1:0]        frame_len;
  logic [LW-1:0]        slot;
  logic [N_SAMPLES-1:0] asm_en;
  logic [BIT_WIDTH-1:0] asm_q [N_SAMPLES];
  logic [BIT_WIDTH-1:0] out_d [N_SAMPLES];

  serdes_deser_db_ctrl #(
    .N_SAMPLES (N_SAMPLES),
    .LW        (LW),
    .CW        (CW)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .cfg_len   (cfg_len),
    .send_val  (send_val),
    .send_rdy  (send_rdy),
    .send_len  (send_len),
    .wr_en     (wr_en),
    .count     (count),
    .cur_len   (cur_len),
    .frame_len (frame_len),
    .move      (move)
  );

  // Destination slot of the accepted word.
  always_comb begin
    slot = LW'(count);
    if (REVERSE != 0) slot = cur_len - LW'(1) - LW'(count);
  end

  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_slot
    assign asm_en[i] = wr_en && (slot == LW'(i));
    // Stale words from a longer earlier frame are masked on the move.
    assign out_d[i]  = (LW'(i) < frame_len) ? asm_q[i] : '0;

    cmn_EnResetReg #(.p_nbits(BIT_WIDTH)) u_asm (
      .clk   (clk),
      .reset (reset),
      .en    (asm_en[i]),
      .d     (recv_msg),
      .q     (asm_q[i])
    );

    cmn_EnResetReg #(.p_nbits(BIT_WIDTH)) u_out (
      .clk   (clk),
      .reset (reset),
      .en    (move),
      .d     (out_d[i]),
      .q     (send_msg[i])
    );
  end

endmodule

// File: tb/tb_serdes_deserializer_db.sv
module tb_serdes_deserializer_db;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset;
  logic          recv_val;
  logic [W-1:0]  recv_msg;
  logic [LW-1:0] cfg_len;
  logic          send_rdy;

  logic          rdy0, rdy1, sval0, sval1;
  logic [W-1:0]  msg0 [N-1:0];
  logic [W-1:0]  msg1 [N-1:0];
  logic [LW-1:0] slen0, slen1;

  logic [W-1:0]  exp0 [N];
  logic [W-1:0]  exp1 [N];

  int unsigned checks = 0;
  int unsigned errors = 0;

  serdes_deserializer_db #(.N_SAMPLES(N), .BIT_WIDTH(W), .REVERSE(0)) dut0 (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rdy0),
    .recv_msg(recv_msg), .cfg_len(cfg_len), .send_val(sval0),
    .send_rdy(send_rdy), .send_msg(msg0), .send_len(slen0)
  );

  serdes_deserializer_db #(.N_SAMPLES(N), .BIT_WIDTH(W), .REVERSE(1)) dut1 (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rdy1),
    .recv_msg(recv_msg), .cfg_len(cfg_len), .send_val(sval1),
    .send_rdy(send_rdy), .send_msg(msg1), .send_len(slen1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < N; i++) begin
      exp0[i] = '0;
      exp1[i] = '0;
    end
  endtask

  task automatic check_frame(input string tag, input logic exp_val,
                             input logic [LW-1:0] exp_len, input bit both);
    check_eq({tag, "_val0"}, 64'(sval0), 64'(exp_val));
    check_eq({tag, "_len0"}, 64'(slen0), 64'(exp_len));
    for (int i = 0; i < N; i++)
      check_eq($sformatf("%s_msg0[%0d]", tag, i), 64'(msg0[i]), 64'(exp0[i]));
    if (both) begin
      check_eq({tag, "_val1"}, 64'(sval1), 64'(exp_val));
      check_eq({tag, "_len1"}, 64'(slen1), 64'(exp_len));
      for (int i = 0; i < N; i++)
        check_eq($sformatf("%s_msg1[%0d]", tag, i), 64'(msg1[i]), 64'(exp1[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted; returns 1 time unit after
  // the accepting edge with recv_val dropped.
  task automatic push(input logic [W-1:0] w, input logic [LW-1:0] len);
    int unsigned n;
    n = 0;
    recv_val = 1'b1;
    recv_msg = w;
    cfg_len  = len;
    @(negedge clk);
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("push_timeout", 64'(rdy0), 64'(1));
    tick();
    recv_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] clamp_lens [2];
    int unsigned   t0;

    reset    = 1'b1;
    recv_val = 1'b0;
    recv_msg = '0;
    cfg_len  = LW'(8);
    send_rdy = 1'b1;
    clear_exp();

    // Reset state
    tick(); tick();
    check_frame("rst", 1'b0, '0, 1);
    reset = 1'b0;
    tick();
    check_eq("rst_rdy", 64'(rdy0), 64'(1));

    // Basic 8-word frame, latency 2
    for (int k = 0; k < 8; k++) push(W'(k + 1), LW'(8));
    check_eq("t1_early", 64'(sval0), 64'(0));
    tick();
    for (int i = 0; i < N; i++) begin
      exp0[i] = W'(i + 1);
      exp1[i] = W'(8 - i);
    end
    check_frame("t1", 1'b1, LW'(8), 1);

    // Short frame, stale slots masked
    push(32'hAAAA_0001, LW'(3));
    push(32'hBBBB_0002, LW'(3));
    push(32'hCCCC_0003, LW'(3));
    check_eq("t2_early", 64'(sval0), 64'(0));
    tick();
    clear_exp();
    exp0[0] = 32'hAAAA_0001; exp0[1] = 32'hBBBB_0002; exp0[2] = 32'hCCCC_0003;
    exp1[2] = 32'hAAAA_0001; exp1[1] = 32'hBBBB_0002; exp1[0] = 32'hCCCC_0003;
    check_frame("t2", 1'b1, LW'(3), 1);

    // Length change mid-frame
    push(32'h40, LW'(4));
    push(32'h41, LW'(2));
    push(32'h42, LW'(2));
    push(32'h43, LW'(2));
    check_eq("t3a_early", 64'(sval0), 64'(0));
    tick();
    clear_exp();
    for (int i = 0; i < 4; i++) exp0[i] = W'(32'h40 + i);
    check_frame("t3a", 1'b1, LW'(4), 0);
    push(32'h50, LW'(2));
    push(32'h51, LW'(2));
    check_eq("t3b_early", 64'(sval0), 64'(0));
    tick();
    clear_exp();
    exp0[0] = 32'h50; exp0[1] = 32'h51;
    check_frame("t3b", 1'b1, LW'(2), 0);

    // Clamping of 0 and out-of-range lengths
    clamp_lens[0] = LW'(0);
    clamp_lens[1] = LW'(15);
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 8; k++) push(W'(32'h60 + 16 * c + k), clamp_lens[c]);
      check_eq($sformatf("t4_%0d_early", c), 64'(sval0), 64'(0));
      tick();
      for (int i = 0; i < N; i++) begin
        exp0[i] = W'(32'h60 + 16 * c + i);
        exp1[i] = W'(32'h60 + 16 * c + 7 - i);
      end
      check_frame($sformatf("t4_%0d", c), 1'b1, LW'(8), 1);
    end

    // frame_len = 1: one frame per word, no bubble
    push(32'h71, LW'(1));
    check_eq("t5_early", 64'(sval0), 64'(0));
    push(32'h72, LW'(1));
    clear_exp();
    exp0[0] = 32'h71; exp1[0] = 32'h71;
    check_frame("t5a", 1'b1, LW'(1), 1);
    push(32'h73, LW'(1));
    exp0[0] = 32'h72; exp1[0] = 32'h72;
    check_frame("t5b", 1'b1, LW'(1), 1);
    tick();
    exp0[0] = 32'h73; exp1[0] = 32'h73;
    check_frame("t5c", 1'b1, LW'(1), 1);

    // Throughput with send_rdy held high
    t0 = cyc;
    for (int k = 0; k < 16; k++) push(W'(32'h80 + k), LW'(8));
    check_eq("t6_cycles", 64'(cyc - t0), 64'(16));
    tick();
    for (int i = 0; i < N; i++) exp0[i] = W'(32'h88 + i);
    check_frame("t6", 1'b1, LW'(8), 0);
    tick();

    // Backpressure: two frames buffered, then drained in order
    send_rdy = 1'b0;
    for (int k = 0; k < 16; k++) push(W'(32'h90 + k), LW'(8));
    check_eq("t7_rdy_low", 64'(rdy0), 64'(0));
    for (int i = 0; i < N; i++) exp0[i] = W'(32'h90 + i);
    check_frame("t7_f1", 1'b1, LW'(8), 0);
    repeat (3) tick();
    check_eq("t7_rdy_hold", 64'(rdy0), 64'(0));
    check_frame("t7_f1_hold", 1'b1, LW'(8), 0);
    send_rdy = 1'b1;
    #1;
    check_eq("t7_rdy_comb", 64'(rdy0), 64'(1));
    tick();
    for (int i = 0; i < N; i++) exp0[i] = W'(32'h98 + i);
    check_frame("t7_f2", 1'b1, LW'(8), 0);
    tick();
    check_eq("t7_drain", 64'(sval0), 64'(0));

    // Reset mid-frame discards the partial frame
    for (int k = 0; k < 5; k++) push(W'(32'hA0 + k), LW'(8));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_exp();
    check_frame("t8_rst", 1'b0, '0, 1);
    repeat (4) tick();
    check_eq("t8_idle", 64'(sval0), 64'(0));
    for (int k = 0; k < 8; k++) push(W'(32'hB0 + k), LW'(8));
    check_eq("t8_early", 64'(sval0), 64'(0));
    tick();
    for (int i = 0; i < N; i++) begin
      exp0[i] = W'(32'hB0 + i);
      exp1[i] = W'(32'hB7 - i);
    end
    check_frame("t8", 1'b1, LW'(8), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
